// File: rtl/fixed_to_e4m3.sv
// ---------------------------------------------------------------------------
// fixed_to_e4m3
//
// Converts a signed two's-complement Q12.8 fixed-point value into an 8-bit
// e4m3 float {sign, exp[3:0], mant[2:0]} with exponent bias 7. The block
// processes one value at a time:
//   IDLE  - waits for an input and captures it
//   NORM  - shifts the magnitude left one bit per cycle until it is normalised
//   ROUND - rounds to nearest-even and applies the overflow policy
//   DONE  - holds the result until the consumer takes it
//
// Parameters
//   SATURATE  1: overflow clamps to max finite (0x7E/0xFE); 0: overflow -> NaN
//
// Ports
//   clock      in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   in_data    in   [19:0] Q12.8 value (value = in_data / 256)
//   in_valid   in   in_data valid
//   in_ready   out  high only in IDLE
//   out_data   out  [7:0] e4m3 result
//   out_valid  out  high only in DONE
//   out_ready  in   consumer accepts out_data
// ---------------------------------------------------------------------------
module fixed_to_e4m3 #(
    parameter bit SATURATE = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [19:0] mag_q, mag_d;
    // k tracks the bit index that mag[19] currently represents in the
    // original magnitude; it doubles as (exponent + 1) once normalised.
    logic [4:0]  k_q, k_d;
    logic [7:0]  out_data_q, out_data_d;

    // Rounding datapath, consumed only in ROUND.
    logic [2:0]  mant_trunc;
    logic        guard_bit;
    logic        sticky_bit;
    logic        round_up;
    logic [3:0]  mant_sum;
    logic [4:0]  exp_r;
    logic [2:0]  mant_r;
    logic        overflow;
    logic [7:0]  result;
    logic [19:0] abs_in;

    // |in_data| in 20 bits; -2^19 wraps back to 0x80000, which is the correct
    // unsigned magnitude.
    assign abs_in = in_data[19] ? (~in_data + 20'd1) : in_data;

    always_comb begin
        mant_trunc = mag_q[18:16];
        guard_bit  = mag_q[15];
        sticky_bit = |mag_q[14:0];
        round_up   = guard_bit & (sticky_bit | mant_trunc[0]);
        mant_sum   = {1'b0, mant_trunc} + {3'b000, round_up};
        // A mantissa carry-out leaves mant_sum[2:0] == 0 and bumps the exponent.
        exp_r      = k_q - 5'd1 + {4'b0000, mant_sum[3]};
        mant_r     = mant_sum[2:0];
        overflow   = (exp_r > 5'd15) || ((exp_r == 5'd15) && (mant_r == 3'd7));

        if (k_q == 5'd1) begin
            // Subnormal or zero: the two surviving bits are exact. The sign is
            // masked on zero so that a zero result is always 0x00.
            result = {sign_q & (mag_q[19] | mag_q[18]), 4'b0000,
                      mag_q[19], mag_q[18], 1'b0};
        end else if (overflow) begin
            result = SATURATE ? {sign_q, 7'b1111110} : {sign_q, 7'b1111111};
        end else begin
            result = {sign_q, exp_r[3:0], mant_r};
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        mag_d      = mag_q;
        k_d        = k_q;
        out_data_d = out_data_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_data[19];
                    mag_d   = abs_in;
                    k_d     = 5'd19;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mag_q[19] || (k_q == 5'd1)) begin
                    state_d = ROUND;
                end else begin
                    mag_d = {mag_q[18:0], 1'b0};
                    k_d   = k_q - 5'd1;
                end
            end
            ROUND: begin
                out_data_d = result;
                state_d    = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            mag_q      <= '0;
            k_q        <= '0;
            out_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            mag_q      <= mag_d;
            k_q        <= k_d;
            out_data_q <= out_data_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_fixed_to_e4m3.sv
// ---------------------------------------------------------------------------
// tb_fixed_to_e4m3
//
// Drives two instances of fixed_to_e4m3 (SATURATE=1 and SATURATE=0) with the
// same stimulus. Expected results and latencies come from a reference model
// that picks the nearest e4m3 code by exhaustive search; they are queued when
// an input is accepted and popped when the DUT raises out_valid.
// ---------------------------------------------------------------------------
module tb_fixed_to_e4m3;

    logic        clock;
    logic        reset;
    logic [19:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready_a,  in_ready_b;
    logic [7:0]  out_data_a,  out_data_b;
    logic        out_valid_a, out_valid_b;

    typedef struct {
        logic [7:0] sat1;
        logic [7:0] sat0;
        int         lat;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    fixed_to_e4m3 #(.SATURATE(1'b1)) u_dut_sat (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .out_data  (out_data_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready)
    );

    fixed_to_e4m3 #(.SATURATE(1'b0)) u_dut_nan (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .out_data  (out_data_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Positive e4m3 code value in units of 2^-9.
    function automatic int unsigned code_val(input int unsigned c);
        int unsigned e;
        int unsigned m;
        e = (c >> 3) & 15;
        m = c & 7;
        if (e == 0) return m;
        return (8 + m) << (e - 1);
    endfunction

    function automatic logic [7:0] model(input logic [19:0] d, input bit sat);
        int unsigned mag;
        int unsigned target;
        int unsigned best;
        int unsigned best_diff;
        int unsigned diff;
        int unsigned v;
        logic        s;
        s      = d[19];
        mag    = s ? (32'h0010_0000 - {12'h000, d}) : {12'h000, d};
        target = mag * 2;
        // Halfway between 448 and 480 ties to 448; anything above overflows.
        if (target > 464 * 512) begin
            return sat ? {s, 7'h7E} : {s, 7'h7F};
        end
        best      = 0;
        best_diff = 32'hFFFF_FFFF;
        for (int c = 0; c < 127; c++) begin
            v    = code_val(c);
            diff = (v > target) ? (v - target) : (target - v);
            if ((diff < best_diff) || ((diff == best_diff) && ((c % 2) == 0))) begin
                best      = c;
                best_diff = diff;
            end
        end
        return {s && (best != 0), best[6:0]};
    endfunction

    function automatic int model_lat(input logic [19:0] d);
        logic [19:0] mag;
        int          kl;
        mag = d[19] ? (~d + 20'd1) : d;
        kl  = 0;
        for (int i = 0; i < 20; i++) begin
            if (mag[i]) kl = i;
        end
        if (kl < 1) kl = 1;
        return 21 - kl;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready_a && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!in_ready_a) check("ready_timeout", 32'(in_ready_a), 32'd1);
    endtask

    task automatic accept(input logic [19:0] d);
        exp_t e;
        wait_ready();
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clock);
        e.sat1 = model(d, 1'b1);
        e.sat0 = model(d, 1'b0);
        e.lat  = model_lat(d);
        sb.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_one(input logic [19:0] d, input int bp);
        exp_t        e;
        int          lat;
        logic [7:0]  held;
        logic [31:0] junk;
        accept(d);
        lat = 0;
        while (!out_valid_a && lat < 40) begin
            // Stray in_valid pulses during conversion must be ignored.
            junk     = $urandom;
            in_data  = junk[19:0];
            in_valid = junk[20];
            @(posedge clock);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check("out_valid_seen", 32'(out_valid_a), 32'd1);
        if (sb.size() == 0) begin
            check("sb_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check($sformatf("lat_%05h", d), 32'(lat), 32'(e.lat));
        check($sformatf("sat_%05h", d), 32'(out_data_a), 32'(e.sat1));
        check($sformatf("nan_%05h", d), 32'(out_data_b), 32'(e.sat0));
        check("valid_b", 32'(out_valid_b), 32'd1);
        held = out_data_a;
        for (int i = 0; i < bp; i++) begin
            junk     = $urandom;
            in_data  = junk[19:0];
            in_valid = 1'b1;
            check("bp_in_ready", 32'(in_ready_a), 32'd0);
            @(posedge clock);
            #1;
            check("bp_valid", 32'(out_valid_a), 32'd1);
            check("bp_data", 32'(out_data_a), 32'(held));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid_a), 32'd0);
        check("post_ready", 32'(in_ready_a), 32'd1);
        check("post_hold", 32'(out_data_a), 32'(held));
    endtask

    initial begin
        logic [19:0] dirs [16];
        logic [31:0] r;
        dirs = '{20'h00200, 20'h00048, 20'hFFC00, 20'h00013, 20'h00011, 20'h00000,
                 20'h00001, 20'h00003, 20'h7FFFF, 20'h80000, 20'h1D000, 20'h1D001,
                 20'h1C000, 20'hFFFFF, 20'h00002, 20'h0001F};

        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_valid", 32'(out_valid_a), 32'd0);
        check("rst_data", 32'(out_data_a), 32'h00);
        check("rst_ready", 32'(in_ready_a), 32'd1);

        foreach (dirs[i]) begin
            run_one(dirs[i], (dirs[i] == 20'h80000) ? 5 : (i % 3));
        end

        // Reset mid-NORM discards the conversion.
        accept(20'h00200);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb.delete();
        check("midrst_valid", 32'(out_valid_a), 32'd0);
        check("midrst_data", 32'(out_data_a), 32'h00);
        check("midrst_ready", 32'(in_ready_a), 32'd1);
        run_one(20'h00200, 0);

        // Reset wins over an accept at the same edge.
        in_data  = 20'h00200;
        in_valid = 1'b1;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        check("rst_prio_ready", 32'(in_ready_a), 32'd1);
        check("rst_prio_valid", 32'(out_valid_a), 32'd0);

        for (int i = 0; i < 24; i++) begin
            r = $urandom;
            if (i % 2 == 0) run_one(r[19:0], 0);
            else            run_one({{12{r[31]}}, r[7:0]}, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fixed_to_e4m3.md
FIXED_TO_E4M3 -- requirements
Module: fixed_to_e4m3

Interface
REQ-001 SHALL have parameter SATURATE, default 1, overflow policy: 1 = clamp to max finite, 0 = emit NaN.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_data  input  20  signed two's-complement Q12.8 value (value = in_data/256).
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_ready  output  1  block can accept input.
REQ-007 SHALL have port out_data  output  8  e4m3 result {sign, exp[3:0], mant[2:0]}, bias 7.
REQ-008 SHALL have port out_valid  output  1  out_data valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_data.

Function
REQ-010 SHALL implement states IDLE, NORM, ROUND, DONE; one conversion in flight at a time.
REQ-011 SHALL assert in_ready only in IDLE; in_valid & in_ready at an edge is an accept.
REQ-012 On accept, SHALL latch sign = in_data[19], mag = |in_data| as 20-bit unsigned (0x80000 -> mag 0x80000), k = 19, and go to NORM.
REQ-013 In NORM, each cycle: if mag[19]==1 or k==1, go to ROUND; else mag <= mag<<1, k <= k-1.
REQ-014 In ROUND with k==1 (subnormal/zero): exp = 0, mant = {mag[19], mag[18], 0}; exact, no rounding.
REQ-015 In ROUND with k>=2 (normal): exp = k-1, mant = mag[18:16], guard = mag[15], sticky = OR(mag[14:0]).
REQ-016 Normal rounding SHALL be round-to-nearest-even: increment mant if guard & (sticky | mant[0]); mant carry-out sets mant=0, exp+1.
REQ-017 Overflow SHALL be exp>15, or exp==15 with mant==111; result {sign,1111110} if SATURATE=1, else {sign,1111111}.
REQ-018 Zero input SHALL yield 0x00 (never 0x80).
REQ-019 ROUND SHALL register out_data and go to DONE; out_valid high exactly in DONE.
REQ-020 Latency from accept edge to first cycle with out_valid high SHALL be 21 - max(kl,1) cycles, kl = index of leading one of original mag (zero -> 20 cycles; full scale -> 2 cycles).
REQ-021 In DONE, out_data and out_valid SHALL hold stable while out_ready is low; out_valid & out_ready at an edge returns to IDLE.
REQ-022 in_valid in any non-IDLE state SHALL be ignored; no back-to-back overlap (minimum one IDLE cycle between results).
REQ-023 out_data SHALL change only on ROUND->DONE transition or reset.

Reset
REQ-024 When reset is high at a rising edge, SHALL go to IDLE, out_valid=0, out_data=0x00, in_ready=1 next cycle, discarding any in-flight conversion.
REQ-025 reset SHALL take priority over accept and handshake events in the same cycle.

Verification
REQ-026 in_data=0x00200 (2.0) -> out_data 0x40 after 12 cycles; in_data=0x00048 (0.28125) -> 0x29; in_data=0xFFC00 (-4.0) -> 0xC8.
REQ-027 Rounding: in_data=0x00013 -> 0x1A (tie, round up to even); in_data=0x00011 -> 0x18 (tie, stay even); in_data=0x00000 -> 0x00 after 20 cycles.
REQ-028 Subnormal: in_data=0x00001 -> 0x02; 0x00003 -> 0x06; both after 20 cycles.
REQ-029 Overflow: in_data=0x7FFFF -> 0x7E and 0x80000 -> 0xFE with SATURATE=1; 0x7FFFF -> 0x7F with SATURATE=0; latency 2 cycles.
REQ-030 Backpressure: out_ready low 5 cycles in DONE -> out_data/out_valid stable, in_ready low, extra in_valid pulses ignored; release -> IDLE next cycle.
REQ-031 Reset asserted mid-NORM -> next cycle out_valid=0, out_data=0x00, in_ready=1; following conversion of 0x00200 -> 0x40 correct.
